// File: rtl/lemming_pkg.sv
// Shared types and helpers for the lemming lane controller and its multi-lane wrapper.
package lemming_pkg;

  typedef enum logic [2:0] {
    ST_WALK_L = 3'd0,
    ST_WALK_R = 3'd1,
    ST_DIG_L  = 3'd2,
    ST_DIG_R  = 3'd3,
    ST_FALL_L = 3'd4,
    ST_FALL_R = 3'd5,
    ST_SPLAT  = 3'd6
  } state_e;

  // One-hot output decode, bit order {splat, digging, aaah, walk_right, walk_left}
  localparam int          OUT_W      = 5;
  localparam logic [4:0]  OUT_WALK_L = 5'b00001;
  localparam logic [4:0]  OUT_WALK_R = 5'b00010;
  localparam logic [4:0]  OUT_FALL   = 5'b00100;
  localparam logic [4:0]  OUT_DIG    = 5'b01000;
  localparam logic [4:0]  OUT_SPLAT  = 5'b10000;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lemming_lane.sv
// Single lemming: walk/dig/fall/splat FSM with a saturating fall-length counter.
module lemming_lane
  import lemming_pkg::*;
#(
  parameter int FALL_LIMIT = 20,
  parameter bit DIG_EN     = 1'b1
) (
  input  logic clk,
  input  logic areset_n,
  input  logic bump_left_i,
  input  logic bump_right_i,
  input  logic ground_i,
  input  logic dig_i,
  input  logic revive_i,
  output logic walk_left_o,
  output logic walk_right_o,
  output logic aaah_o,
  output logic digging_o,
  output logic splat_o
);

  localparam int            CW    = cnt_width(FALL_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(FALL_LIMIT);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               falling;
  logic [OUT_W-1:0]   out_vec;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_WALK_L;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign falling = (state_q == ST_FALL_L) || (state_q == ST_FALL_R);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WALK_L: begin
        if (!ground_i)               state_d = ST_FALL_L;
        else if (DIG_EN && dig_i)    state_d = ST_DIG_L;
        else if (bump_left_i)        state_d = ST_WALK_R;
      end
      ST_WALK_R: begin
        if (!ground_i)               state_d = ST_FALL_R;
        else if (DIG_EN && dig_i)    state_d = ST_DIG_R;
        else if (bump_right_i)       state_d = ST_WALK_L;
      end
      ST_DIG_L:  if (!ground_i) state_d = ST_FALL_L;
      ST_DIG_R:  if (!ground_i) state_d = ST_FALL_R;
      // Landing compares the length accumulated before this edge
      ST_FALL_L: if (ground_i) state_d = (cnt_q >= LIMIT) ? ST_SPLAT : ST_WALK_L;
      ST_FALL_R: if (ground_i) state_d = (cnt_q >= LIMIT) ? ST_SPLAT : ST_WALK_R;
      ST_SPLAT:  if (revive_i) state_d = ST_WALK_L;
      default:   state_d = ST_WALK_L;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (falling) cnt_d = (cnt_q >= LIMIT) ? LIMIT : cnt_q + CW'(1);
  end

  always_comb begin
    out_vec = OUT_WALK_L;
    unique case (state_q)
      ST_WALK_L:           out_vec = OUT_WALK_L;
      ST_WALK_R:           out_vec = OUT_WALK_R;
      ST_DIG_L,  ST_DIG_R:  out_vec = OUT_DIG;
      ST_FALL_L, ST_FALL_R: out_vec = OUT_FALL;
      ST_SPLAT:            out_vec = OUT_SPLAT;
      default:             out_vec = OUT_WALK_L;
    endcase
  end

  assign {splat_o, digging_o, aaah_o, walk_right_o, walk_left_o} = out_vec;

endmodule

// File: rtl/lemming_array.sv
// N independent lemming lanes plus aggregate survivor count and all-dead flag.
module lemming_array
  import lemming_pkg::*;
#(
  parameter int N_LANES    = 4,
  parameter int FALL_LIMIT = 20,
  parameter bit DIG_EN     = 1'b1
) (
  input  logic                            clk,
  input  logic                            areset_n,
  input  logic [N_LANES-1:0]              bump_left,
  input  logic [N_LANES-1:0]              bump_right,
  input  logic [N_LANES-1:0]              ground,
  input  logic [N_LANES-1:0]              dig,
  input  logic [N_LANES-1:0]              revive,
  output logic [N_LANES-1:0]              walk_left,
  output logic [N_LANES-1:0]              walk_right,
  output logic [N_LANES-1:0]              aaah,
  output logic [N_LANES-1:0]              digging,
  output logic [N_LANES-1:0]              splat,
  output logic [cnt_width(N_LANES)-1:0]   alive_count,
  output logic                            all_dead
);

  localparam int AW = cnt_width(N_LANES);

  logic [AW-1:0] dead_cnt;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    lemming_lane #(
      .FALL_LIMIT (FALL_LIMIT),
      .DIG_EN     (DIG_EN)
    ) u_lane (
      .clk          (clk),
      .areset_n     (areset_n),
      .bump_left_i  (bump_left[g]),
      .bump_right_i (bump_right[g]),
      .ground_i     (ground[g]),
      .dig_i        (dig[g]),
      .revive_i     (revive[g]),
      .walk_left_o  (walk_left[g]),
      .walk_right_o (walk_right[g]),
      .aaah_o       (aaah[g]),
      .digging_o    (digging[g]),
      .splat_o      (splat[g])
    );
  end

  always_comb begin
    dead_cnt = '0;
    for (int i = 0; i < N_LANES; i++) dead_cnt = dead_cnt + AW'(splat[i]);
  end

  assign alive_count = AW'(N_LANES) - dead_cnt;
  assign all_dead    = (alive_count == '0);

endmodule

// File: tb/tb_lemming_array.sv
// Scoreboard bench for lemming_array: per-edge expectations from a behavioural lane model.
module tb_lemming_array;

  localparam int NL  = 4;
  localparam int LIM = 20;

  logic          clk = 1'b0;
  logic          areset_n = 1'b0;
  logic [NL-1:0] bump_left = '0, bump_right = '0, ground = '1, dig = '0, revive = '0;
  logic [NL-1:0] walk_left, walk_right, aaah, digging, splat;
  logic [2:0]    alive_count;
  logic          all_dead;

  lemming_array #(.N_LANES(NL), .FALL_LIMIT(LIM), .DIG_EN(1'b1)) dut (
    .clk(clk), .areset_n(areset_n),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground),
    .dig(dig), .revive(revive),
    .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah),
    .digging(digging), .splat(splat),
    .alive_count(alive_count), .all_dead(all_dead)
  );

  always #5 clk = ~clk;

  // Behavioural model: each lemming is described by independent flags
  bit m_dead[NL], m_fall[NL], m_dig[NL], m_right[NL];
  int m_len[NL];

  logic [23:0] exp_q[$];
  event        sample_ev;
  int          n_cmp = 0, n_bad = 0;

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) begin
      m_dead[i] = 0; m_fall[i] = 0; m_dig[i] = 0; m_right[i] = 0; m_len[i] = 0;
    end
  endfunction

  function automatic void model_step(input logic [NL-1:0] bl, br, gr, dg, rv);
    for (int i = 0; i < NL; i++) begin
      if (m_dead[i]) begin
        if (rv[i]) begin m_dead[i] = 0; m_right[i] = 0; end
      end else if (m_fall[i]) begin
        if (gr[i]) begin
          m_fall[i] = 0;
          if (m_len[i] >= LIM) m_dead[i] = 1;
        end else m_len[i]++;
      end else if (!gr[i]) begin
        m_fall[i] = 1; m_dig[i] = 0; m_len[i] = 0;
      end else if (!m_dig[i]) begin
        if (dg[i]) m_dig[i] = 1;
        else if (m_right[i] ? br[i] : bl[i]) m_right[i] = !m_right[i];
      end
    end
  endfunction

  function automatic logic [23:0] model_out();
    logic [NL-1:0] wl, wr, fa, di, sp;
    int alive;
    alive = 0;
    for (int i = 0; i < NL; i++) begin
      sp[i] = m_dead[i];
      fa[i] = !m_dead[i] && m_fall[i];
      di[i] = !m_dead[i] && !m_fall[i] && m_dig[i];
      wl[i] = !m_dead[i] && !m_fall[i] && !m_dig[i] && !m_right[i];
      wr[i] = !m_dead[i] && !m_fall[i] && !m_dig[i] && m_right[i];
      if (!m_dead[i]) alive++;
    end
    return {wl, wr, fa, di, sp, 3'(alive), (alive == 0)};
  endfunction

  // Monitor: one expectation per active edge, plus one per asynchronous reset assertion
  initial begin
    logic [23:0] act, expv;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (exp_q.size() != 0) begin
        expv = exp_q.pop_front();
        act  = {walk_left, walk_right, aaah, digging, splat, alive_count, all_dead};
        n_cmp++;
        if (act !== expv) begin
          n_bad++;
          $display("FAIL outputs t=%0t got {wl,wr,aaah,dig,splat,alive,dead}=%h expected %h",
                   $time, act, expv);
        end
      end
    end
  end

  task automatic cyc(input logic [NL-1:0] bl, br, gr, dg, rv);
    @(negedge clk);
    areset_n = 1'b1;
    bump_left = bl; bump_right = br; ground = gr; dig = dg; revive = rv;
    model_step(bl, br, gr, dg, rv);
    exp_q.push_back(model_out());
  endtask

  task automatic idle();
    cyc('0, '0, '1, '0, '0);
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk);
    #2;
    areset_n = 1'b0;
    model_reset();
    exp_q.push_back(model_out());
    ->sample_ev;
    repeat (hold) begin
      @(negedge clk);
      bump_left = 4'($urandom); bump_right = 4'($urandom); ground = 4'($urandom);
      dig = 4'($urandom); revive = 4'($urandom);
      exp_q.push_back(model_out());
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NL-1:0] gs, bl, br, dg, rv;
    model_reset();
    do_reset(2);
    repeat (5) idle();
    // Bumps on lane 0
    cyc(4'b0001, '0, '1, '0, '0); idle();
    cyc(4'b0001, 4'b0001, '1, '0, '0); idle();
    cyc('0, 4'b0001, '1, '0, '0); idle();
    // Lane 1 fall lengths: survive, die, saturate
    repeat (20) cyc('0, '0, 4'b1101, '0, '0); repeat (2) idle();
    repeat (21) cyc('0, '0, 4'b1101, '0, '0); repeat (2) idle();
    cyc('0, '0, '1, '0, 4'b0010); idle();
    repeat (300) cyc('0, '0, 4'b1101, '0, '0); repeat (2) idle();
    cyc('0, '0, '1, '0, 4'b0010); idle();
    // Lane 2 dig then fall
    cyc(4'b0100, '0, '1, '0, '0);
    cyc('0, '0, '1, 4'b0100, '0); idle();
    cyc(4'b0100, 4'b0100, '1, 4'b0100, '0);
    repeat (3) cyc('0, '0, 4'b1011, '0, '0); repeat (2) idle();
    // Everyone dies, selective revive, revive while walking
    repeat (25) cyc('0, '0, '0, '0, '0); repeat (2) idle();
    cyc('0, '0, '1, '0, 4'b0100); idle();
    cyc('0, '0, '1, '0, 4'b0100); idle();
    cyc('0, '0, '1, '0, 4'b1111); idle();
    // Reset in the middle of a lane 3 fall, then a fresh survivable fall
    repeat (16) cyc('0, '0, 4'b0111, '0, '0);
    do_reset(1);
    repeat (20) cyc('0, '0, 4'b0111, '0, '0); repeat (2) idle();
    // Randomised phase with sticky ground so long falls occur
    gs = '1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NL; i++) if ($urandom_range(15) == 0) gs[i] = !gs[i];
      bl = 4'($urandom); br = 4'($urandom);
      for (int i = 0; i < NL; i++) begin
        dg[i] = ($urandom_range(7) == 0);
        rv[i] = ($urandom_range(15) == 0);
      end
      if ($urandom_range(499) == 0) do_reset($urandom_range(2));
      else cyc(bl, br, gs, dg, rv);
    end
    repeat (2) idle();
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lemming_array.md
# lemming_array

Parametrised multi-lane Lemmings controller: N independent lemming FSMs share one clock and reset. Each lane walks, turns on bumps, digs, falls, and dies on a fall longer than a configurable limit. It adds a per-lane revive input and aggregate survivor status that the single-lemming block lacks. It sits at the top of the game-logic layer and feeds the renderer and score logic.

## Interface
- N_LANES, default 4: number of independent lemmings, 1..32.
- FALL_LIMIT, default 20: a fall lasting this many cycles or more is fatal on landing, 1..255.
- DIG_EN, default 1: 0 ignores `dig` on all lanes.
- Reset and clock: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- areset_n  in  1  asynchronous active-low reset.
- bump_left  in  N_LANES  per-lane left-wall bump.
- bump_right  in  N_LANES  per-lane right-wall bump.
- ground  in  N_LANES  per-lane ground present.
- dig  in  N_LANES  per-lane dig request.
- revive  in  N_LANES  per-lane revive request; effective only in SPLAT.
- walk_left  out  N_LANES  lane in WALK_L.
- walk_right  out  N_LANES  lane in WALK_R.
- aaah  out  N_LANES  lane in FALL_L or FALL_R.
- digging  out  N_LANES  lane in DIG_L or DIG_R.
- splat  out  N_LANES  lane in SPLAT.
- alive_count  out  $clog2(N_LANES+1)  number of lanes not in SPLAT.
- all_dead  out  1  every lane is in SPLAT.

## Operation
- Per-lane states: WALK_L, WALK_R, DIG_L, DIG_R, FALL_L, FALL_R, SPLAT. Lanes never interact.
- WALK_x transitions, in priority order:
  - !ground -> FALL_x.
  - DIG_EN && dig -> DIG_x.
  - Bump on the facing side, or both bumps -> WALK of the opposite direction.
  - Otherwise stay in WALK_x.
- A bump on the non-facing side is ignored.
- DIG_x: !ground -> FALL_x; otherwise stay. Bumps and dig are ignored.
- FALL_x:
  - ground=0 -> stay.
  - ground=1 and fall_cnt >= FALL_LIMIT -> SPLAT.
  - ground=1 otherwise -> WALK_x. Direction is preserved.
  - Bumps, dig and revive are ignored.
- SPLAT: revive=1 -> WALK_L with fall_cnt cleared; otherwise stay.
- fall_cnt, per lane, width $clog2(FALL_LIMIT+1):
  - Increments on every clock edge the lane is in FALL_x.
  - Saturates at FALL_LIMIT; it never wraps.
  - Cleared on any edge the lane is not in FALL_x.
- Outputs are Moore, decoded from state only. Exactly one of walk_left/walk_right/aaah/digging/splat is 1 per lane.
- alive_count = N_LANES minus popcount(splat). all_dead = (alive_count == 0).
- Reset (areset_n=0) takes effect immediately, mid-fall or mid-dig included:
  - All lanes go to WALK_L with fall_cnt = 0.
  - Outputs: walk_left = all ones, all other per-lane outputs 0, alive_count = N_LANES, all_dead = 0.

## Timing
- State and fall_cnt are registered on the rising clk edge. Outputs change one cycle after the causing input is sampled.
- Fall length is counted as the number of edges spent in FALL_x.
  - Lane enters FALL at edge 0 with !ground sampled; landing sampled at edge k has fall_cnt = k-1.
  - FALL_LIMIT=20: ground returning at edge 21 or later -> SPLAT; at edge 20 or earlier -> survive.
- Revive: SPLAT -> WALK_L in one cycle. alive_count increments in the same cycle walk_left rises.
- Release of areset_n is synchronised externally. The first edge after release evaluates normally from WALK_L.

## Structure
- Shared package lemming_pkg holds:
  - The state enum (3 bits).
  - Output-decode constants.
  - A count-width function.
- Sub-module lemming_lane: one FSM plus fall counter, parameters FALL_LIMIT and DIG_EN. It is instantiated N_LANES times by a generate loop.
- The top level holds only the lane instances and the popcount / all_dead logic.

## Test plan
- Reset, then ground=all 1 with no other inputs for 5 cycles -> walk_left=4'hF, alive_count=4, all_dead=0 throughout.
- Lane 0 WALK_L, bump_left=1 for one cycle -> walk_right[0]=1 next cycle. Bump both sides in WALK_R -> walk_left[0]=1. Bump_right in WALK_L -> no change.
- Lane 1 ground=0 for 20 cycles then 1 -> walk_left[1]=1. Ground=0 for 21 cycles then 1 -> splat[1]=1, alive_count=3. Ground=0 for 300 cycles then 1 -> splat[1]=1 (saturation, no wrap).
- Lane 2 in WALK_R, dig=1 -> digging[2]=1. Then ground=0 -> aaah[2]=1. Landing after 3 cycles -> walk_right[2]=1.
- All lanes fall 25 cycles and land -> all_dead=1, alive_count=0. Revive=4'b0100 -> only lane 2 walk_left=1, alive_count=1. Revive asserted in WALK -> no effect.
- Assert areset_n=0 mid-fall on lane 3 with fall_cnt=15 -> immediate walk_left=4'hF. A new 20-cycle fall after release survives (counter cleared).
